instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have no parameters; widths are fixed: instruction 16 bits, register address 3 bits, immediate 8 bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports, in order:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- INSTR  input  16  instruction word: [15:12] opcode, [11:9] DR, [8:6] SA, [5:3] SB, [5:0] LDI immediate
- INSTR_VALID  input  1  INSTR is valid this cycle
- INSTR_READY  output  1  sequencer accepts INSTR this cycle
- SA  output  3  register-file read port A select
- SB  output  3  register-file read port B select
- DR  output  3  register-file destination select
- LD  output  1  register-file write enable, one-cycle pulse
- ALU_OP  output  4  ALU operation, equal to the opcode
- MUX_B  output  1  1 selects IMM instead of DATA_B
- IMM  output  8  zero-extended immediate
- BUSY  output  1  high in any state other than IDLE
- ILLEGAL  output  1  one-cycle pulse on a reserved opcode
- HALTED  output  1  high in HALT state

Function
REQ-004 SHALL implement FSM states IDLE, DECODE, EXEC, WB and HALT.
REQ-005 In IDLE, INSTR_READY SHALL be 1; a transfer occurs when INSTR_VALID=1 and INSTR_READY=1; on transfer, INSTR SHALL be captured into IR and the FSM SHALL go to DECODE.
REQ-006 In all states other than IDLE, INSTR_READY SHALL be 0; INSTR_VALID SHALL be ignored.
REQ-007 From DECODE entry through the end of WB, SA, SB, DR, ALU_OP, MUX_B and IMM SHALL be driven from IR and held stable.
REQ-008 Opcode handling:
- 0 NOP: DECODE->IDLE; no LD.
- 1-7 (MOV, ADD, SUB, AND, OR, XOR, NOT): DECODE->EXEC->WB->IDLE; MUX_B=0.
- 8 LDI: same path; MUX_B=1; IMM={2'b00,IR[5:0]}.
- 9-14 reserved: treated as NOP; ILLEGAL SHALL pulse for the DECODE cycle.
- 15: DECODE->HALT.
REQ-009 LD SHALL be 1 only during WB, for exactly one cycle per write instruction.
REQ-010 Latency SHALL be 3 clocks from the transfer edge to the LD-high cycle; write-instruction throughput SHALL be 1 per 4 clocks; NOP throughput SHALL be 1 per 2 clocks.
REQ-011 HALT SHALL persist until reset; in HALT, INSTR_READY=0, LD=0, HALTED=1.
REQ-012 When not in DECODE, EXEC or WB, IMM and MUX_B SHALL be 0, and SA, SB, DR SHALL hold their last values.
REQ-013 DR equal to SA or SB (e.g. ADD R1,R1,R1) SHALL be legal; no special handling is required.

Reset
REQ-014 When RST_N=0, regardless of CLK: state=IDLE, IR=0, SA=SB=DR=0, LD=0, ALU_OP=0, MUX_B=0, IMM=0, BUSY=0, ILLEGAL=0, HALTED=0, INSTR_READY=0.
REQ-015 INSTR_READY SHALL rise on the first CLK edge after RST_N deasserts.
REQ-016 Reset asserted mid-instruction SHALL abort the instruction with no LD pulse.

Configuration
REQ-017 Macro SEQ_PERF_CNT_EN.
- Defined: add output INSTR_COUNT [15:0], reset to 0, incremented on each transfer, wrapping 0xFFFF->0x0000.
- Undefined: port and counter are absent.

Structure
REQ-018 Opcode constants, the FSM state encoding and the instruction field bit positions SHALL live in shared package seq_pkg.
REQ-019 Decode SHALL be a combinational sub-module instr_decode (IR in; ALU_OP, MUX_B, IMM, is_write, is_halt, is_illegal out); the FSM SHALL remain in instr_sequencer.

Verification
REQ-020 Bench SHALL cover:
- ADD R3,R1,R2 (0x2650) accepted at edge T -> SA=1, SB=2 from T+1; LD=1 with DR=3 and ALU_OP=2 in cycle T+3; INSTR_READY=1 at T+4.
- LDI R5,0x2A (0x8A2A) -> MUX_B=1, IMM=0x2A, DR=5, LD one cycle.
- Opcode 0xA -> ILLEGAL pulses once; no LD; INSTR_READY back after 2 clocks.
- 0xF000 then a held INSTR_VALID -> HALTED=1, INSTR_READY stays 0, no LD; RST_N pulse -> IDLE.
- RST_N asserted during EXEC -> outputs reset immediately; no LD.
- With SEQ_PERF_CNT_EN, 0x10000 NOPs -> INSTR_COUNT wraps to 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM encoding, IR field positions.
// Optional build macro used by the top: SEQ_PERF_CNT_EN.
`timescale 1ns/1ps
package seq_pkg;

   localparam int INSTR_W = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int DR_MSB  = 11;
   localparam int DR_LSB  = 9;
   localparam int SA_MSB  = 8;
   localparam int SA_LSB  = 6;
   localparam int SB_MSB  = 5;
   localparam int SB_LSB  = 3;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] ir);
      return ir[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode decode of the instruction register.
`timescale 1ns/1ps
module instr_decode
   import seq_pkg::*;
(
   input  logic [INSTR_W-1:0] IR,
   output logic [3:0]         ALU_OP,
   output logic               MUX_B,
   output logic [7:0]         IMM,
   output logic               is_write,
   output logic               is_halt,
   output logic               is_illegal
);

   logic [3:0] op;
   // Register-select fields are consumed by the top, not here.
   logic       unused_fields;

   assign op            = opcode_of(IR);
   assign unused_fields = ^IR[DR_MSB:SA_LSB];

   always_comb begin
      ALU_OP     = op;
      MUX_B      = (op == OP_LDI);
      IMM        = 8'h00;
      is_write   = (op >= OP_MOV) && (op <= OP_LDI);
      is_halt    = (op == OP_HALT);
      is_illegal = (op > OP_LDI) && (op < OP_HALT);
      if (op == OP_LDI) begin
         IMM = {2'b00, IR[IMM_MSB:IMM_LSB]};
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: IDLE -> DECODE -> (EXEC -> WB) -> IDLE, or HALT until reset.
// Define SEQ_PERF_CNT_EN to add the INSTR_COUNT transfer counter output.
`timescale 1ns/1ps
module instr_sequencer
   import seq_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [INSTR_W-1:0] INSTR,
   input  logic               INSTR_VALID,
   output logic               INSTR_READY,
   output logic [2:0]         SA,
   output logic [2:0]         SB,
   output logic [2:0]         DR,
   output logic               LD,
   output logic [3:0]         ALU_OP,
   output logic               MUX_B,
   output logic [7:0]         IMM,
   output logic               BUSY,
   output logic               ILLEGAL,
   output logic               HALTED
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0]        INSTR_COUNT
`endif
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               armed_q;
   logic               transfer;
   logic               in_flight;

   logic [3:0] dec_alu_op;
   logic       dec_mux_b;
   logic [7:0] dec_imm;
   logic       dec_write;
   logic       dec_halt;
   logic       dec_illegal;

   instr_decode u_decode (
      .IR         (ir_q),
      .ALU_OP     (dec_alu_op),
      .MUX_B      (dec_mux_b),
      .IMM        (dec_imm),
      .is_write   (dec_write),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );

   // armed_q keeps READY low until the first clock edge after reset release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         armed_q <= 1'b1;
      end
   end

   assign INSTR_READY = armed_q && (state_q == ST_IDLE);
   assign transfer    = INSTR_READY && INSTR_VALID;

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               ir_d    = INSTR;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_halt) begin
               state_d = ST_HALT;
            end else if (dec_write) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Register selects come straight from IR, so they hold until the next transfer.
   assign in_flight = (state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB);
   assign SA        = ir_q[SA_MSB:SA_LSB];
   assign SB        = ir_q[SB_MSB:SB_LSB];
   assign DR        = ir_q[DR_MSB:DR_LSB];
   assign ALU_OP    = dec_alu_op;
   assign MUX_B     = in_flight && dec_mux_b;
   assign IMM       = in_flight ? dec_imm : 8'h00;
   assign LD        = (state_q == ST_WB);
   assign ILLEGAL   = (state_q == ST_DECODE) && dec_illegal;
   assign BUSY      = (state_q != ST_IDLE);
   assign HALTED    = (state_q == ST_HALT);

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] count_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q <= 16'h0000;
      end else if (transfer) begin
         count_q <= count_q + 16'h0001;
      end
   end

   assign INSTR_COUNT = count_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed table, hand-written corner sequences, random stream.
`timescale 1ns/1ps
module tb_instr_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] INSTR;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [2:0]  SA, SB, DR;
   logic        LD;
   logic [3:0]  ALU_OP;
   logic        MUX_B;
   logic [7:0]  IMM;
   logic        BUSY, ILLEGAL, HALTED;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] INSTR_COUNT;
`endif

   instr_sequencer dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .INSTR       (INSTR),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .SA          (SA),
      .SB          (SB),
      .DR          (DR),
      .LD          (LD),
      .ALU_OP      (ALU_OP),
      .MUX_B       (MUX_B),
      .IMM         (IMM),
      .BUSY        (BUSY),
      .ILLEGAL     (ILLEGAL),
      .HALTED      (HALTED)
`ifdef SEQ_PERF_CNT_EN
      ,
      .INSTR_COUNT (INSTR_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] sa, sb, dr;
      logic [3:0] op;
      logic       muxb;
      logic [7:0] imm;
      logic       write;
      logic       illegal;
      int         len;
   } exp_t;

   typedef struct {
      logic [15:0] instr;
      exp_t        e;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: fields and behaviour from plain arithmetic on the instruction word.
   function automatic exp_t model(input logic [15:0] w);
      exp_t e;
      int v;
      int op;
      v         = int'(w);
      op        = v / 4096;
      e.op      = 4'(op);
      e.dr      = 3'((v / 512) % 8);
      e.sa      = 3'((v / 64) % 8);
      e.sb      = 3'((v / 8) % 8);
      e.write   = (op >= 1) && (op <= 8);
      e.illegal = (op >= 9) && (op <= 14);
      e.muxb    = (op == 8);
      e.imm     = (op == 8) ? 8'(v % 64) : 8'h00;
      e.len     = e.write ? 4 : 2;
      return e;
   endfunction

   // Called right after a negedge with the DUT idle; ends at the negedge where it is idle again.
   task automatic run_instr(input logic [15:0] w, input exp_t e, input bit noisy);
      check("ready_before", 32'(INSTR_READY), 32'd1);
      INSTR       = w;
      INSTR_VALID = 1'b1;
      for (int k = 1; k <= e.len; k++) begin
         @(negedge CLK);
         if (k < e.len) begin
            check($sformatf("busy@%0d", k),    32'(BUSY),        32'd1);
            check($sformatf("ready@%0d", k),   32'(INSTR_READY), 32'd0);
            check($sformatf("ld@%0d", k),      32'(LD),          32'(e.write && (k == 3)));
            check($sformatf("illegal@%0d", k), 32'(ILLEGAL),     32'(e.illegal && (k == 1)));
            check($sformatf("sa@%0d", k),      32'(SA),          32'(e.sa));
            check($sformatf("sb@%0d", k),      32'(SB),          32'(e.sb));
            check($sformatf("dr@%0d", k),      32'(DR),          32'(e.dr));
            check($sformatf("alu_op@%0d", k),  32'(ALU_OP),      32'(e.op));
            check($sformatf("mux_b@%0d", k),   32'(MUX_B),       32'(e.muxb));
            check($sformatf("imm@%0d", k),     32'(IMM),         32'(e.imm));
            check($sformatf("halted@%0d", k),  32'(HALTED),      32'd0);
            if (noisy) begin
               INSTR_VALID = 1'($urandom);
               INSTR       = 16'($urandom);
            end else begin
               INSTR_VALID = 1'b0;
            end
         end else begin
            check("ready_after", 32'(INSTR_READY), 32'd1);
            check("busy_after",  32'(BUSY),        32'd0);
            check("ld_after",    32'(LD),          32'd0);
            check("mux_b_idle",  32'(MUX_B),       32'd0);
            check("imm_idle",    32'(IMM),         32'd0);
            check("sa_hold",     32'(SA),          32'(e.sa));
            check("dr_hold",     32'(DR),          32'(e.dr));
            INSTR_VALID = 1'b0;
         end
      end
      $display("txn instr=%04h op=%0d write=%0d illegal=%0d cycles=%0d", w, e.op, e.write, e.illegal, e.len);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[9];
      vecs[0] = '{16'h2650, '{3'd1, 3'd2, 3'd3, 4'd2,  1'b0, 8'h00, 1'b1, 1'b0, 4}};
      vecs[1] = '{16'h8A2A, '{3'd0, 3'd5, 3'd5, 4'd8,  1'b1, 8'h2A, 1'b1, 1'b0, 4}};
      vecs[2] = '{16'hA123, '{3'd4, 3'd4, 3'd0, 4'd10, 1'b0, 8'h00, 1'b0, 1'b1, 2}};
      vecs[3] = '{16'h0000, '{3'd0, 3'd0, 3'd0, 4'd0,  1'b0, 8'h00, 1'b0, 1'b0, 2}};
      vecs[4] = '{16'h1E47, '{3'd1, 3'd0, 3'd7, 4'd1,  1'b0, 8'h00, 1'b1, 1'b0, 4}};
      vecs[5] = '{16'h7FFF, '{3'd7, 3'd7, 3'd7, 4'd7,  1'b0, 8'h00, 1'b1, 1'b0, 4}};
      vecs[6] = '{16'h2249, '{3'd1, 3'd1, 3'd1, 4'd2,  1'b0, 8'h00, 1'b1, 1'b0, 4}};
      vecs[7] = '{16'hE000, '{3'd0, 3'd0, 3'd0, 4'd14, 1'b0, 8'h00, 1'b0, 1'b1, 2}};
      vecs[8] = '{16'h9000, '{3'd0, 3'd0, 3'd0, 4'd9,  1'b0, 8'h00, 1'b0, 1'b1, 2}};

      RST_N       = 1'b0;
      INSTR_VALID = 1'b0;
      INSTR       = 16'h0000;

      // Reset state
      #2;
      check("rst_ready",   32'(INSTR_READY), 32'd0);
      check("rst_busy",    32'(BUSY),        32'd0);
      check("rst_ld",      32'(LD),          32'd0);
      check("rst_sa",      32'(SA),          32'd0);
      check("rst_dr",      32'(DR),          32'd0);
      check("rst_alu_op",  32'(ALU_OP),      32'd0);
      check("rst_imm",     32'(IMM),         32'd0);
      check("rst_halted",  32'(HALTED),      32'd0);
      repeat (2) @(negedge CLK);
      check("rst_ready_clocked", 32'(INSTR_READY), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("ready_first_edge", 32'(INSTR_READY), 32'd1);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         run_instr(vecs[i].instr, vecs[i].e, (i % 2) == 1);
      end

      // Random stream with idle gaps
      for (int n = 0; n < 40; n++) begin
         logic [15:0] w;
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            check("gap_ready", 32'(INSTR_READY), 32'd1);
            check("gap_ld",    32'(LD),          32'd0);
         end
         w = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr(w, model(w), 1'b1);
      end

      // HALT with VALID held, then reset recovery
      INSTR       = 16'hF000;
      INSTR_VALID = 1'b1;
      @(negedge CLK);
      check("halt_decode_busy",   32'(BUSY),   32'd1);
      check("halt_decode_halted", 32'(HALTED), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         check("halt_halted", 32'(HALTED),      32'd1);
         check("halt_ready",  32'(INSTR_READY), 32'd0);
         check("halt_ld",     32'(LD),          32'd0);
      end
      $display("txn instr=f000 halt held 8 cycles");
      RST_N = 1'b0;
      #1;
      check("halt_rst_halted", 32'(HALTED),      32'd0);
      check("halt_rst_busy",   32'(BUSY),        32'd0);
      check("halt_rst_ready",  32'(INSTR_READY), 32'd0);
      @(negedge CLK);
      RST_N       = 1'b1;
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      check("halt_recover_ready", 32'(INSTR_READY), 32'd1);

      // Reset during EXEC aborts the write
      INSTR       = 16'h2650;
      INSTR_VALID = 1'b1;
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      check("abort_exec_busy", 32'(BUSY), 32'd1);
      RST_N = 1'b0;
      #1;
      check("abort_ready",  32'(INSTR_READY), 32'd0);
      check("abort_busy",   32'(BUSY),        32'd0);
      check("abort_ld",     32'(LD),          32'd0);
      check("abort_sa",     32'(SA),          32'd0);
      check("abort_sb",     32'(SB),          32'd0);
      check("abort_dr",     32'(DR),          32'd0);
      check("abort_alu_op", 32'(ALU_OP),      32'd0);
      @(negedge CLK);
      check("abort_ld_wb_slot", 32'(LD), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("abort_recover_ready", 32'(INSTR_READY), 32'd1);
      check("abort_recover_ld",    32'(LD),          32'd0);
      $display("txn instr=2650 aborted by reset in EXEC");

`ifdef SEQ_PERF_CNT_EN
      // Counter wrap over 0x10000 back-to-back NOPs (one transfer every two edges)
      check("cnt_start", 32'(INSTR_COUNT), 32'd0);
      INSTR       = 16'h0000;
      INSTR_VALID = 1'b1;
      repeat (32'h1FFFE) @(negedge CLK);
      check("cnt_ffff", 32'(INSTR_COUNT), 32'h0000FFFF);
      repeat (2) @(negedge CLK);
      INSTR_VALID = 1'b0;
      check("cnt_wrap", 32'(INSTR_COUNT), 32'd0);
      $display("txn 65536 NOPs counted, counter=%04h", INSTR_COUNT);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
